// File: rtl/usb_nrzi_stuff_encode.sv
// Transmit-side USB line encoder: bit stuffing, NRZI encoding and EOP generation onto D+/D-.
// One bit time per clk; a bit consumed in cycle N is on the line in cycle N+1.
module usb_nrzi_stuff_encode #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  input  logic start_encode,
  input  logic end_encode,
  input  logic abort,
  output logic dp,
  output logic dm,
  output logic tx_en,
  output logic stuff_wait,
  output logic encode_wait,
  output logic eop_done
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam int SW = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          tx_en_q, tx_en_d;
  logic          eop_done_q, eop_done_d;
  logic          end_pend_q, end_pend_d;
  logic [CW-1:0] ones_cnt_q, ones_cnt_d;
  logic [SW-1:0] se0_cnt_q, se0_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      tx_en_q    <= 1'b0;
      eop_done_q <= 1'b0;
      end_pend_q <= 1'b0;
      ones_cnt_q <= '0;
      se0_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      tx_en_q    <= tx_en_d;
      eop_done_q <= eop_done_d;
      end_pend_q <= end_pend_d;
      ones_cnt_q <= ones_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    tx_en_d    = tx_en_q;
    eop_done_d = 1'b0;
    end_pend_d = end_pend_q;
    ones_cnt_d = ones_cnt_q;
    se0_cnt_d  = se0_cnt_q;

    case (state_q)
      S_IDLE: begin
        dp_d       = 1'b1;
        dm_d       = 1'b0;
        tx_en_d    = 1'b0;
        ones_cnt_d = '0;
        end_pend_d = 1'b0;
        if (start_encode) begin
          state_d = S_DATA;
          tx_en_d = 1'b1;
        end
      end
      S_DATA: begin
        if (!s_in) begin
          // NRZI: a zero is a transition, dm always the complement of dp
          dp_d       = ~dp_q;
          dm_d       = dp_q;
          ones_cnt_d = '0;
          if (end_encode) begin
            state_d   = S_EOP_SE0;
            se0_cnt_d = '0;
          end
        end else if (ones_cnt_q == CW'(STUFF_LEN - 1)) begin
          ones_cnt_d = CW'(STUFF_LEN);
          end_pend_d = end_encode;
          state_d    = S_STUFF;
        end else begin
          ones_cnt_d = ones_cnt_q + CW'(1);
          if (end_encode) begin
            state_d   = S_EOP_SE0;
            se0_cnt_d = '0;
          end
        end
      end
      S_STUFF: begin
        dp_d       = ~dp_q;
        dm_d       = dp_q;
        ones_cnt_d = '0;
        if (end_pend_q) begin
          state_d   = S_EOP_SE0;
          se0_cnt_d = '0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_EOP_SE0: begin
        dp_d      = 1'b0;
        dm_d      = 1'b0;
        se0_cnt_d = se0_cnt_q + SW'(1);
        if (se0_cnt_q == SW'(EOP_SE0_BITS - 1)) begin
          state_d = S_EOP_J;
        end
      end
      S_EOP_J: begin
        dp_d       = 1'b1;
        dm_d       = 1'b0;
        tx_en_d    = 1'b1;
        eop_done_d = 1'b1;
        end_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      dp_d       = 1'b1;
      dm_d       = 1'b0;
      tx_en_d    = 1'b0;
      eop_done_d = 1'b0;
      end_pend_d = 1'b0;
      ones_cnt_d = '0;
      se0_cnt_d  = '0;
    end
  end

  assign dp          = dp_q;
  assign dm          = dm_q;
  assign tx_en       = tx_en_q;
  assign eop_done    = eop_done_q;
  assign stuff_wait  = (state_q == S_STUFF);
  assign encode_wait = (state_q == S_IDLE);

endmodule

// File: tb/tb_usb_nrzi_stuff_encode.sv
// Bench for usb_nrzi_stuff_encode: expected line activity comes from a stuffed-bit-stream
// plus NRZI level model, compared every bit time.
module tb_usb_nrzi_stuff_encode;
  localparam int STUFF_LEN = 6;
  localparam int SE0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_in = 1'b0;
  logic start_encode = 1'b0;
  logic end_encode = 1'b0;
  logic abort = 1'b0;
  logic dp, dm, tx_en, stuff_wait, encode_wait, eop_done;

  int errors = 0;
  int checks = 0;

  logic       bits [0:63];
  int         nbits;
  logic       stream_bit [0:127];
  logic       stream_stf [0:127];
  logic [3:0] exp_out [0:159];
  int         slen;

  usb_nrzi_stuff_encode #(.STUFF_LEN(STUFF_LEN), .EOP_SE0_BITS(SE0)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .start_encode(start_encode),
    .end_encode(end_encode), .abort(abort), .dp(dp), .dm(dm), .tx_en(tx_en),
    .stuff_wait(stuff_wait), .encode_wait(encode_wait), .eop_done(eop_done)
  );

  always #5 clk = ~clk;

  // stop_mode: 0 none, 1 abort at cycle stop_at, 2 async reset in first SE0 bit time
  task automatic run_pkt(input string name, input int stop_at, input int stop_mode);
    int ones, len, idx, stop_i;
    logic lvl;
    logic [5:0] obs, expv;
    slen = 0;
    ones = 0;
    for (int b = 0; b < nbits; b++) begin
      stream_bit[slen] = bits[b];
      stream_stf[slen] = 1'b0;
      slen++;
      if (bits[b]) ones++; else ones = 0;
      if (ones == STUFF_LEN) begin
        stream_bit[slen] = 1'b0;
        stream_stf[slen] = 1'b1;
        slen++;
        ones = 0;
      end
    end
    lvl = 1'b1;
    for (int j = 0; j < slen; j++) begin
      if (!stream_bit[j]) lvl = ~lvl;
      exp_out[j] = {lvl, ~lvl, 1'b1, 1'b0};
    end
    for (int s = 0; s < SE0; s++) exp_out[slen + s] = 4'b0010;
    exp_out[slen + SE0]     = 4'b1011;
    exp_out[slen + SE0 + 1] = 4'b1000;
    len = slen + SE0 + 2;
    stop_i = (stop_mode == 2) ? slen + 2 : ((stop_mode == 1) ? stop_at : -1);

    @(negedge clk);
    start_encode = 1'b1;
    end_encode = 1'b0;
    s_in = 1'($urandom_range(0, 1));
    idx = 0;
    for (int i = 1; i <= len + 1; i++) begin
      @(negedge clk);
      start_encode = 1'b0;
      if (i == 1) begin
        expv = 6'b101000;
      end else begin
        expv[5:2] = exp_out[i-2];
        expv[1] = (i - 1 < slen) ? stream_stf[i-1] : 1'b0;
        expv[0] = (i - 1 > slen + SE0);
      end
      obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s bit %0d: {dp,dm,tx_en,eop_done,stuff_wait,encode_wait} got %b expected %b",
                 name, i, obs, expv);
      end
      if (i == stop_i) begin
        if (stop_mode == 1) begin
          abort = 1'b1;
          start_encode = 1'($urandom_range(0, 1));
          for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            abort = 1'b0;
            start_encode = 1'b0;
            obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
            checks++;
            if (obs !== 6'b100001) begin
              errors++;
              $display("FAIL %s after abort +%0d: got %b expected 100001", name, k, obs);
            end
          end
        end else begin
          #1 rst = 1'b1;
          #1;
          obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
          checks++;
          if (obs !== 6'b100001) begin
            errors++;
            $display("FAIL %s async reset: got %b expected 100001", name, obs);
          end
          for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
            checks++;
            if (obs !== 6'b100001) begin
              errors++;
              $display("FAIL %s held reset +%0d: got %b expected 100001", name, k, obs);
            end
          end
          rst = 1'b0;
        end
        s_in = 1'b0;
        end_encode = 1'b0;
        return;
      end
      if (idx < nbits) begin
        s_in = bits[idx];
        end_encode = (idx == nbits - 1);
        if (!stuff_wait) idx++;
      end else begin
        s_in = 1'($urandom_range(0, 1));
        end_encode = 1'($urandom_range(0, 1));
      end
      if (i - 1 <= slen + SE0) start_encode = 1'($urandom_range(0, 1));
    end
    s_in = 1'b0;
    end_encode = 1'b0;
    start_encode = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
      checks++;
      if (obs !== 6'b100001) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected 100001", k, obs);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    nbits = 5;
    bits[0] = 0; bits[1] = 0; bits[2] = 1; bits[3] = 1; bits[4] = 0;
    run_pkt("basic", -1, 0);
  endtask

  task automatic test_stuffing();
    nbits = 8;
    for (int b = 0; b < 7; b++) bits[b] = 1'b1;
    bits[7] = 1'b0;
    run_pkt("stuffing", -1, 0);
  endtask

  task automatic test_end_on_stuff();
    nbits = 6;
    for (int b = 0; b < 6; b++) bits[b] = 1'b1;
    run_pkt("end_on_stuff", -1, 0);
  endtask

  task automatic test_abort();
    logic [5:0] obs;
    nbits = 8;
    for (int b = 0; b < 8; b++) bits[b] = 1'b1;
    run_pkt("abort_mid", 6, 1);
    nbits = 5;
    for (int b = 0; b < 5; b++) bits[b] = 1'b1;
    run_pkt("after_abort", -1, 0);
    @(negedge clk);
    start_encode = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start_encode = 1'b0;
    abort = 1'b0;
    obs = {dp, dm, tx_en, eop_done, stuff_wait, encode_wait};
    checks++;
    if (obs !== 6'b100001) begin
      errors++;
      $display("FAIL abort_vs_start: got %b expected 100001", obs);
    end
  endtask

  task automatic test_reset_in_eop();
    nbits = 4;
    bits[0] = 1; bits[1] = 0; bits[2] = 1; bits[3] = 1;
    run_pkt("reset_in_eop", -1, 2);
    nbits = 3;
    bits[0] = 0; bits[1] = 1; bits[2] = 0;
    run_pkt("after_reset", -1, 0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      nbits = $urandom_range(1, 40);
      for (int b = 0; b < nbits; b++) bits[b] = ($urandom_range(0, 3) != 0);
      run_pkt("random", -1, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      nbits = 12;
      for (int b = 0; b < 12; b++) bits[b] = (b != 11);
      run_pkt("back_to_back", -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_end_on_stuff();
    test_abort();
    test_reset_in_eop();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
